axi_txn_arbiter: RTL

Transaction-level arbiter that shares one AXI slave port between two masters (s0, s1). Each transaction is granted to exactly one master and held from address phase through completion: B handshake for writes, last R beat for reads. The grant is then released and re-arbitrated round-robin. The block sits in front of the interconnect's slave-side mux and drives its select lines; it carries no payload.

---
 rtl/axi_arb_pkg.sv | 17 +
 rtl/axi_rr_pick.sv | 21 ++
 rtl/axi_txn_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the two-master AXI transaction arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    typedef logic owner_t;

    // Master index to one-hot select for the slave-side mux.
    function automatic logic [1:0] onehot_grant(input owner_t owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/axi_rr_pick.sv
// Two-way round-robin picker: a lone requester wins; on a tie the master
// that did not own the port last time wins.
module axi_rr_pick
    import axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output logic       valid,
    output owner_t     winner
);

    // Tie goes to the master that was not last owner.
    always_comb begin
        valid  = |req;
        winner = req[1];
        if (req == 2'b11) begin
            winner = ~last_owner;
        end
    end

endmodule

// File: rtl/axi_txn_arbiter.sv
// Transaction-level arbiter sharing one AXI slave port between two masters.
// A grant is held from address phase through B (write) or last R (read).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ARB_IDLE | no owner, grant 2'b00; arbitrate any pending AW/AR request
// ARB_ADDR | owner granted, waiting for its AW or AR handshake
// ARB_DATA | address accepted, waiting for B handshake or last R beat
module axi_txn_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s0_awvalid,
    input  logic       s0_arvalid,
    input  logic       s1_awvalid,
    input  logic       s1_arvalid,
    input  logic       m_awready,
    input  logic       m_arready,
    input  logic       m_bvalid,
    input  logic       m_bready,
    input  logic       m_rvalid,
    input  logic       m_rready,
    input  logic       m_rlast,
    output logic [1:0] grant,
    output logic       grant_wr,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] CNT_LIM = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    arb_state_t    state_q, state_d;
    owner_t        owner_q, owner_d;
    owner_t        last_owner_q, last_owner_d;
    logic          wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    grant_q, grant_d;
    logic          grant_wr_q, grant_wr_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;

    logic          pick_valid;
    owner_t        pick_winner;
    logic          own_aw, own_ar;
    logic          addr_hs, data_done, wdog_fire;

    axi_rr_pick u_pick (
        .req        ({s1_awvalid | s1_arvalid, s0_awvalid | s0_arvalid}),
        .last_owner (last_owner_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // Owner-qualified handshakes and watchdog expiry.
    always_comb begin
        own_aw    = owner_q ? s1_awvalid : s0_awvalid;
        own_ar    = owner_q ? s1_arvalid : s0_arvalid;
        addr_hs   = wr_q ? (own_aw && m_awready) : (own_ar && m_arready);
        data_done = wr_q ? (m_bvalid && m_bready) : (m_rvalid && m_rready && m_rlast);
        wdog_fire = WDOG_EN && (cnt_q == CNT_LIM);
    end

    // Next-state, watchdog counter and registered-output decode.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        wr_d         = wr_q;
        timeout_d    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_ADDR;
                    owner_d = pick_winner;
                    wr_d    = pick_winner ? s1_awvalid : s0_awvalid;
                end
            end
            ARB_ADDR: begin
                if (addr_hs) begin
                    state_d = ARB_DATA;
                end else if (wdog_fire) begin
                    state_d      = ARB_IDLE;
                    timeout_d    = 1'b1;
                    last_owner_d = owner_q;
                end
            end
            ARB_DATA: begin
                // Completion beats a coincident watchdog expiry.
                if (data_done) begin
                    state_d      = ARB_IDLE;
                    last_owner_d = owner_q;
                end else if (wdog_fire) begin
                    state_d      = ARB_IDLE;
                    timeout_d    = 1'b1;
                    last_owner_d = owner_q;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != ARB_IDLE && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        busy_d     = (state_d != ARB_IDLE);
        grant_d    = busy_d ? onehot_grant(owner_d) : 2'b00;
        grant_wr_d = busy_d && wr_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            wr_q         <= 1'b0;
            cnt_q        <= '0;
            grant_q      <= 2'b00;
            grant_wr_q   <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            wr_q         <= wr_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            grant_wr_q   <= grant_wr_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
        end
    end

    assign grant    = grant_q;
    assign grant_wr = grant_wr_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;

endmodule
